norm_shift_ctrl: RTL and testbench
==================================

NORM_SHIFT_CTRL -- requirements
Module: norm_shift_ctrl

Interface
REQ-001 Parameter MANT_W, default 27, sets the adder-output mantissa width: hidden bit, 23 fraction bits, guard, round and sticky.
REQ-002 Parameter EXP_W, default 8, sets the biased exponent width.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  mant_in, exp_in and ovf_in are valid this cycle.
REQ-006 in_ready  output  1  block can accept an operand; high only in IDLE.
REQ-007 mant_in  input  MANT_W  raw adder magnitude, bit MANT_W-1 is the hidden-bit position.
REQ-008 exp_in  input  EXP_W  exponent of the larger operand before normalization.
REQ-009 ovf_in  input  1  adder carry-out.
REQ-010 out_valid  output  1  result is held stable on the outputs.
REQ-011 out_ready  input  1  the consumer accepts the result.
REQ-012 mant_out  output  MANT_W  normalized mantissa.
REQ-013 exp_out  output  EXP_W  adjusted exponent.
REQ-014 shift_cnt  output  5  number of left shifts applied.
REQ-015 zero_out  output  1  the result is exactly zero.
REQ-016 denorm_out  output  1  normalization stopped at the minimum exponent, giving a denormal result.
REQ-017 inf_out  output  1  exponent overflow; exp_out is all-ones and mant_out is all-zeros.
REQ-018 busy  output  1  state is not IDLE.

Function
REQ-019 The state machine SHALL have the states IDLE, NORM and DONE, encoded in 2 bits.
REQ-020 In IDLE, when in_valid and in_ready are both high at a clock edge, the block SHALL register mant_in, exp_in and ovf_in, clear shift_cnt and all flags, and move to NORM.
REQ-021 Each NORM cycle SHALL apply exactly one step, with checks in this priority order:
  - a) ovf_reg=1: mant = {1'b1, mant[MANT_W-1:2], mant[1]|mant[0]}, which right-shifts and keeps the sticky bit; exp = exp+1; clear ovf_reg; go to DONE. If exp+1 equals all-ones: set inf_out, mant = 0.
  - b) mant==0: exp = 0; set zero_out; go to DONE.
  - c) mant[MANT_W-1]==1: go to DONE with no change.
  - d) exp<=1: exp = 0; set denorm_out; go to DONE with the mantissa unchanged.
  - e) otherwise: mant = mant<<1 with a zero fill; exp = exp-1; shift_cnt = shift_cnt+1; stay in NORM.
REQ-022 A left shift SHALL always be exactly one bit per cycle; shift_cnt SHALL never exceed MANT_W-1.
REQ-023 Exponent arithmetic SHALL use EXP_W+1 bits internally; exp_out SHALL never wrap.
REQ-024 In DONE, out_valid SHALL be high and all result outputs SHALL stay stable until out_ready is sampled high.
REQ-025 On the clock edge where out_ready is high in DONE, the block SHALL move to IDLE.
REQ-026 The earliest new accept SHALL be the cycle after the return to IDLE; there is no bypass.
REQ-027 While busy, in_valid SHALL be ignored and in_ready SHALL be 0.
REQ-028 Latency from the accept edge to out_valid high SHALL be 2 cycles with no left shift or with ovf, and 2+k cycles for k left shifts.
REQ-029 All outputs SHALL be driven from registers or decoded only from state, with no combinational path from input to output.

Reset
REQ-030 When rst_n=0, the block SHALL immediately enter IDLE.
REQ-031 During reset, mant_out, exp_out, shift_cnt and all flags SHALL be 0, out_valid and busy SHALL be 0, and in_ready SHALL be 1 once rst_n rises.
REQ-032 Reset asserted in NORM or DONE SHALL abort the operation, and no out_valid SHALL be produced for that operand.

Verification
REQ-033 Normalized input: mant_in=27'h4000000, exp_in=8'd100, ovf_in=0 -> out_valid 2 cycles after accept, mant_out=27'h4000000, exp_out=100, shift_cnt=0.
REQ-034 Three left shifts: mant_in=27'h0800001, exp_in=8'd100 -> out_valid after 5 cycles, mant_out=27'h4000008, exp_out=97, shift_cnt=3.
REQ-035 Overflow: mant_in=27'h0000003, ovf_in=1, exp_in=8'd10 -> mant_out=27'h4000001 with sticky set, exp_out=11; a second case with exp_in=8'd254 -> inf_out=1, exp_out=8'hFF, mant_out=0.
REQ-036 Zero and denormal: mant_in=0 -> zero_out=1, exp_out=0; mant_in=27'h0100000, exp_in=8'd3 -> two shifts, then denorm_out=1, exp_out=0, mant_out=27'h0400000.
REQ-037 Backpressure and reset: hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0 while in_valid is high; assert rst_n=0 mid-NORM -> busy=0 and out_valid=0 immediately, and the next operand is processed correctly.

Source files
------------

// File: rtl/norm_shift_ctrl.sv
// Post-add normalization controller: one left shift per cycle until the hidden
// bit is set, handling adder carry-out, exact zero, denormal stop and exponent overflow.
module norm_shift_ctrl #(
    parameter int unsigned MANT_W = 27,
    parameter int unsigned EXP_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MANT_W-1:0] mant_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic              ovf_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MANT_W-1:0] mant_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [4:0]        shift_cnt,
    output logic              zero_out,
    output logic              denorm_out,
    output logic              inf_out,
    output logic              busy
);

    localparam int unsigned XW    = EXP_W + 1;
    localparam int unsigned CNT_W = 5;
    localparam logic [XW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_n;
    logic [MANT_W-1:0]  mant_q, mant_n;
    logic [EXP_W-1:0]   exp_q, exp_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    logic               ovf_q, ovf_n;
    logic               zero_q, zero_n;
    logic               denorm_q, denorm_n;
    logic               inf_q, inf_n;
    logic               out_valid_q, out_valid_n;
    logic               busy_q, busy_n;
    logic               in_ready_q, in_ready_n;
    logic [XW-1:0]      exp_inc;

    // State and datapath registers; handshake flags are registered from next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mant_q      <= '0;
            exp_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            denorm_q    <= 1'b0;
            inf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_n;
            mant_q      <= mant_n;
            exp_q       <= exp_n;
            cnt_q       <= cnt_n;
            ovf_q       <= ovf_n;
            zero_q      <= zero_n;
            denorm_q    <= denorm_n;
            inf_q       <= inf_n;
            out_valid_q <= out_valid_n;
            busy_q      <= busy_n;
            in_ready_q  <= in_ready_n;
        end
    end

    // Next-state and single-step normalization
    always_comb begin
        state_n  = state_q;
        mant_n   = mant_q;
        exp_n    = exp_q;
        cnt_n    = cnt_q;
        ovf_n    = ovf_q;
        zero_n   = zero_q;
        denorm_n = denorm_q;
        inf_n    = inf_q;
        exp_inc  = {1'b0, exp_q} + XW'(1);

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    mant_n   = mant_in;
                    exp_n    = exp_in;
                    ovf_n    = ovf_in;
                    cnt_n    = '0;
                    zero_n   = 1'b0;
                    denorm_n = 1'b0;
                    inf_n    = 1'b0;
                    state_n  = NORM;
                end
            end
            NORM: begin
                if (ovf_q) begin
                    // Carry-out: right shift by one, folding the dropped bits into sticky
                    ovf_n   = 1'b0;
                    state_n = DONE;
                    if (exp_inc >= EXP_MAX) begin
                        inf_n  = 1'b1;
                        exp_n  = EXP_MAX[EXP_W-1:0];
                        mant_n = '0;
                    end else begin
                        exp_n  = exp_inc[EXP_W-1:0];
                        mant_n = {1'b1, mant_q[MANT_W-1:2], mant_q[1] | mant_q[0]};
                    end
                end else if (mant_q == '0) begin
                    exp_n   = '0;
                    zero_n  = 1'b1;
                    state_n = DONE;
                end else if (mant_q[MANT_W-1]) begin
                    state_n = DONE;
                end else if (exp_q <= EXP_W'(1)) begin
                    exp_n    = '0;
                    denorm_n = 1'b1;
                    state_n  = DONE;
                end else begin
                    mant_n = {mant_q[MANT_W-2:0], 1'b0};
                    exp_n  = exp_q - EXP_W'(1);
                    cnt_n  = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        out_valid_n = (state_n == DONE);
        busy_n      = (state_n != IDLE);
        in_ready_n  = (state_n == IDLE);
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign mant_out   = mant_q;
    assign exp_out    = exp_q;
    assign shift_cnt  = cnt_q;
    assign zero_out   = zero_q;
    assign denorm_out = denorm_q;
    assign inf_out    = inf_q;

endmodule

// File: tb/tb_norm_shift_ctrl.sv
// Scoreboard bench for norm_shift_ctrl: directed operands with hand-computed
// results, checked by an independent monitor on the falling edge.
module tb_norm_shift_ctrl;

    localparam int unsigned MW = 27;
    localparam int unsigned EW = 8;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [MW-1:0] mant_in;
    logic [EW-1:0] exp_in;
    logic          ovf_in;
    logic          out_valid;
    logic          out_ready;
    logic [MW-1:0] mant_out;
    logic [EW-1:0] exp_out;
    logic [4:0]    shift_cnt;
    logic          zero_out;
    logic          denorm_out;
    logic          inf_out;
    logic          busy;

    norm_shift_ctrl #(.MANT_W(MW), .EXP_W(EW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mant_in    (mant_in),
        .exp_in     (exp_in),
        .ovf_in     (ovf_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .mant_out   (mant_out),
        .exp_out    (exp_out),
        .shift_cnt  (shift_cnt),
        .zero_out   (zero_out),
        .denorm_out (denorm_out),
        .inf_out    (inf_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [MW-1:0] mant;
        logic [EW-1:0] exp;
        logic [4:0]    cnt;
        logic          z;
        logic          d;
        logic          i;
        int            lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   acc_cyc  = 0;
    bit   pend     = 0;
    int   stall    = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk(input logic [MW-1:0] m, input logic [EW-1:0] e,
                                input logic [4:0] c, input logic z, input logic d,
                                input logic i, input int lat);
        exp_t r;
        r.mant = m; r.exp = e; r.cnt = c; r.z = z; r.d = d; r.i = i; r.lat = lat;
        return r;
    endfunction

    // Cycle counter and accept-time capture for latency measurement
    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) begin
            acc_cyc = cyc;
            pend    = 1'b1;
        end
        cyc++;
    end

    // Consumer: optionally withhold out_ready for a number of valid cycles
    always @(posedge clk) begin
        #1;
        if (out_valid && stall > 0) begin
            out_ready = 1'b0;
            stall--;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Monitor: every valid cycle is compared against the scoreboard head
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && busy && in_valid)
            chk("in_ready_while_busy", longint'(in_ready), 0);
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_out_valid: actual=1 required=0 (t=%0t)", $time);
            end else begin
                e = sb[0];
                chk("mant_out",   longint'(mant_out),   longint'(e.mant));
                chk("exp_out",    longint'(exp_out),    longint'(e.exp));
                chk("shift_cnt",  longint'(shift_cnt),  longint'(e.cnt));
                chk("zero_out",   longint'(zero_out),   longint'(e.z));
                chk("denorm_out", longint'(denorm_out), longint'(e.d));
                chk("inf_out",    longint'(inf_out),    longint'(e.i));
                if (pend) begin
                    chk("latency", longint'(cyc - acc_cyc), longint'(e.lat));
                    pend = 1'b0;
                end
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic send(input logic [MW-1:0] m, input logic [EW-1:0] e,
                        input logic o, input exp_t x);
        int t;
        @(negedge clk);
        mant_in  = m;
        exp_in   = e;
        ovf_in   = o;
        in_valid = 1'b1;
        sb.push_back(x);
        t = 0;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_remaining", longint'(sb.size()), 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mant_in   = '0;
        exp_in    = '0;
        ovf_in    = 1'b0;
        #13;
        chk("rst_mant_out",  longint'(mant_out), 0);
        chk("rst_exp_out",   longint'(exp_out), 0);
        chk("rst_shift_cnt", longint'(shift_cnt), 0);
        chk("rst_flags",     longint'({zero_out, denorm_out, inf_out}), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy",      longint'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", longint'(in_ready), 1);

        // Already normalized
        send(27'h4000000, 8'd100, 1'b0, mk(27'h4000000, 8'd100, 5'd0, 0, 0, 0, 2));
        // Three left shifts
        send(27'h0800001, 8'd100, 1'b0, mk(27'h4000008, 8'd97, 5'd3, 0, 0, 0, 5));
        // Carry-out with sticky
        send(27'h0000003, 8'd10, 1'b1, mk(27'h4000001, 8'd11, 5'd0, 0, 0, 0, 2));
        // Carry-out into infinity
        send(27'h0000003, 8'd254, 1'b1, mk(27'h0000000, 8'hFF, 5'd0, 0, 0, 1, 2));
        send(27'h7FFFFFF, 8'd255, 1'b1, mk(27'h0000000, 8'hFF, 5'd0, 0, 0, 1, 2));
        send(27'h7FFFFFF, 8'd20, 1'b1, mk(27'h7FFFFFF, 8'd21, 5'd0, 0, 0, 0, 2));
        // Exact zero
        send(27'h0000000, 8'd50, 1'b0, mk(27'h0000000, 8'd0, 5'd0, 1, 0, 0, 2));
        // Denormal after two shifts, and immediate denormal
        send(27'h0100000, 8'd3, 1'b0, mk(27'h0400000, 8'd0, 5'd2, 0, 1, 0, 4));
        send(27'h0001000, 8'd1, 1'b0, mk(27'h0001000, 8'd0, 5'd0, 0, 1, 0, 2));
        // Maximum shift count
        send(27'h0000001, 8'd30, 1'b0, mk(27'h4000000, 8'd4, 5'd26, 0, 0, 0, 28));
        drain();

        // Backpressure with a second operand waiting on in_ready
        stall = 5;
        send(27'h2000000, 8'd9, 1'b0, mk(27'h4000000, 8'd8, 5'd1, 0, 0, 0, 3));
        send(27'h4000001, 8'd200, 1'b0, mk(27'h4000001, 8'd200, 5'd0, 0, 0, 0, 2));
        drain();

        // Reset mid-NORM aborts the operand
        send(27'h0000001, 8'd100, 1'b0, mk(27'h4000000, 8'd74, 5'd26, 0, 0, 0, 28));
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy",      longint'(busy), 0);
        chk("abort_out_valid", longint'(out_valid), 0);
        sb.delete();
        pend = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(27'h0800001, 8'd100, 1'b0, mk(27'h4000008, 8'd97, 5'd3, 0, 0, 0, 5));
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
